// File: rtl/p_s_converter_pkg.sv
// Shared serial-link definitions: FSM encodings common to the transmitter and receiver.
package p_s_converter_pkg;

  localparam int unsigned ST_W = 1;

  localparam logic [ST_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [ST_W-1:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/p_s_converter.sv
// Parallel-to-serial transmitter: MSB-first shift-out with a one-word holding buffer
// so that back-to-back words leave no idle bit between them.
module p_s_converter
  import p_s_converter_pkg::*;
#(
  parameter int unsigned C_BITS_IN    = 8,
  parameter logic        C_IDLE_LEVEL = 1'b0
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic [C_BITS_IN-1:0] D,
  input  logic                 LOAD,
  output logic                 READY,
  output logic                 Q,
  output logic                 FRAME,
  output logic                 BUSY
);

  localparam int unsigned    CNT_W   = (C_BITS_IN > 1) ? $clog2(C_BITS_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_BITS_IN - 1);

  logic [ST_W-1:0]      state, state_n;
  logic [C_BITS_IN-1:0] sreg, sreg_n;
  logic [C_BITS_IN-1:0] hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 accept;
  logic                 q_n, frame_n, busy_n;

  // READY mirrors !hold_full, so acceptance depends only on registered state
  assign accept = LOAD && !hold_full;

  // Next-state and next-output decode
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    cnt_n       = cnt;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          sreg_n  = D;
          cnt_n   = CNT_MAX;
          state_n = ST_SHIFT;
        end
      end
      default: begin
        if (cnt != '0) begin
          sreg_n = {sreg[C_BITS_IN-2:0], 1'b0};
          cnt_n  = cnt - CNT_W'(1);
          if (accept) begin
            hold_n      = D;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          sreg_n      = hold;
          cnt_n       = CNT_MAX;
          hold_full_n = 1'b0;
        end else if (accept) begin
          // Word arriving on the last bit with an empty buffer goes straight to the shifter
          sreg_n = D;
          cnt_n  = CNT_MAX;
        end else begin
          state_n = ST_IDLE;
        end
      end
    endcase

    busy_n  = (state_n == ST_SHIFT);
    q_n     = busy_n ? sreg_n[C_BITS_IN-1] : C_IDLE_LEVEL;
    // Counter only sits at its maximum in the first cycle of a word
    frame_n = busy_n && (cnt_n == CNT_MAX);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      READY     <= 1'b1;
      Q         <= C_IDLE_LEVEL;
      FRAME     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      cnt       <= cnt_n;
      READY     <= !hold_full_n;
      Q         <= q_n;
      FRAME     <= frame_n;
      BUSY      <= busy_n;
    end
  end

endmodule

// File: tb/tb_p_s_converter.sv
// Directed bench for p_s_converter: single word, back-to-back, held LOAD, mid-word reset, loopback.
module tb_p_s_converter;

  logic       ck = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       load;
  logic       load1;
  logic       ready, q, frame, busy;
  logic       ready1, q1, frame1, busy1;
  logic [7:0] rx;

  int checks   = 0;
  int failures = 0;

  p_s_converter #(.C_BITS_IN(8), .C_IDLE_LEVEL(1'b0)) dut (
    .CK(ck), .RST(rst), .D(d), .LOAD(load),
    .READY(ready), .Q(q), .FRAME(frame), .BUSY(busy)
  );

  p_s_converter #(.C_BITS_IN(8), .C_IDLE_LEVEL(1'b1)) dut1 (
    .CK(ck), .RST(rst), .D(d), .LOAD(load1),
    .READY(ready1), .Q(q1), .FRAME(frame1), .BUSY(busy1)
  );

  always #5 ck = ~ck;

  // Receiver-style shift chain fed from the idle-high instance
  always @(posedge ck) begin
    if (rst) rx <= 8'h00;
    else if (busy1) rx <= {rx[6:0], q1};
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".q"},     32'(q),     32'(0));
    chk({tag, ".frame"}, 32'(frame), 32'(0));
    chk({tag, ".busy"},  32'(busy),  32'(0));
    chk({tag, ".ready"}, 32'(ready), 32'(1));
  endtask

  logic [23:0] stream;

  initial begin
    rst = 1'b1; d = 8'h00; load = 1'b0; load1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_idle("reset");
    step(); step(); step();
    chk_idle("reset_hold");

    // Single word 0xA5 loaded in cycle 0
    d = 8'hA5; load = 1'b1;
    step();
    load = 1'b0; d = 8'h00;
    stream = 24'hA50000;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("single.q c%0d", c),     32'(q),     32'(stream[24-c]));
      chk($sformatf("single.frame c%0d", c), 32'(frame), 32'(c == 1));
      chk($sformatf("single.busy c%0d", c),  32'(busy),  32'(1));
      step();
    end
    chk_idle("single_end");
    step();

    // Back-to-back 0xA5 then 0x3C
    d = 8'hA5; load = 1'b1;
    step();
    d = 8'h3C;
    chk("b2b.ready c1", 32'(ready), 32'(1));
    step();
    load = 1'b0; d = 8'h55;
    stream = 24'hA53C00;
    for (int c = 2; c <= 16; c++) begin
      chk($sformatf("b2b.q c%0d", c),     32'(q),     32'(stream[24-c]));
      chk($sformatf("b2b.frame c%0d", c), 32'(frame), 32'(c == 9));
      chk($sformatf("b2b.busy c%0d", c),  32'(busy),  32'(1));
      chk($sformatf("b2b.ready c%0d", c), 32'(ready), 32'(c >= 9));
      step();
    end
    chk_idle("b2b_end");
    step();

    // 0xFF held on LOAD while READY is low; accepted at the end of cycle 9
    d = 8'hA5; load = 1'b1;
    step();
    d = 8'h3C;
    step();
    d = 8'hFF;
    stream = 24'hA53CFF;
    for (int c = 2; c <= 24; c++) begin
      chk($sformatf("held.q c%0d", c),     32'(q),     32'(stream[24-c]));
      chk($sformatf("held.frame c%0d", c), 32'(frame), 32'(c == 9 || c == 17));
      chk($sformatf("held.busy c%0d", c),  32'(busy),  32'(1));
      if (c <= 9) chk($sformatf("held.ready c%0d", c), 32'(ready), 32'(c == 9));
      step();
      if (c == 9) begin
        load = 1'b0; d = 8'h00;
      end
    end
    chk_idle("held_end");
    step();

    // Reset in cycle 4 of 0xA5 with 0x3C held
    d = 8'hA5; load = 1'b1;
    step();
    d = 8'h3C;
    step();
    load = 1'b0; d = 8'h00;
    chk("rst.ready c2", 32'(ready), 32'(0));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_c5");
    for (int c = 6; c <= 20; c++) begin
      chk($sformatf("rst.busy c%0d", c), 32'(busy), 32'(0));
      chk($sformatf("rst.q c%0d", c),    32'(q),    32'(0));
      step();
    end

    // Loopback through idle-high instance
    chk("loop.q_before", 32'(q1), 32'(1));
    d = 8'hA5; load1 = 1'b1;
    step();
    load1 = 1'b0; d = 8'h00;
    chk("loop.frame c1", 32'(frame1), 32'(1));
    for (int c = 1; c <= 8; c++) step();
    chk("loop.rx",      32'(rx),    32'(8'hA5));
    chk("loop.q_after", 32'(q1),    32'(1));
    chk("loop.busy",    32'(busy1), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
